// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared widths, FSM states and the saturated-sample counter helper.
package adc_capture_pkg;
  localparam int NUM_CH = 4;
  localparam int SAMPLE_W = 10;
  localparam int SAMPLES_PER_WORD = 8;
  localparam int WORD_W = SAMPLE_W * SAMPLES_PER_WORD;
  localparam logic [SAMPLE_W-1:0] SAT_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] SAT_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
  typedef enum logic [2:0] {IDLE, ARB, WAIT_VALID, CAPTURE, DONE} state_e;
  function automatic logic [3:0] sat_in_word(input logic [WORD_W-1:0] w);
    logic [SAMPLE_W-1:0] s;
    sat_in_word = '0;
    for (int i = 0; i < SAMPLES_PER_WORD; i++) begin
      s = w[i*SAMPLE_W +: SAMPLE_W];
      if (s == SAT_NEG || s == SAT_POS) sat_in_word = sat_in_word + 4'd1;
    end
  endfunction
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational round-robin pick, searching from the channel after ptr_i.
module rr_arbiter4
  import adc_capture_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [1:0]        ptr_i,
  output logic [NUM_CH-1:0] gnt_o
);
  logic [1:0] idx;
  // Walk from farthest to nearest so the nearest requester is the last to overwrite.
  always_comb begin
    gnt_o = '0;
    idx = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = ptr_i + 2'(i);
      if (req_i[idx]) gnt_o = 4'(1) << idx;
    end
  end
endmodule

// File: rtl/adc_capture_sched.sv
// adc_capture_sched: round-robin capture of one ADC channel into a buffer per grant.
// Optional saturated-sample counting is enabled by defining ADC_CAPTURE_SAT_DETECT_EN.
module adc_capture_sched
  import adc_capture_pkg::*;
#(
  parameter int CAP_LEN = 256,
  parameter int ADDR_W = 9
) (
  input  logic              clk_div_a,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              data_valid,
  input  logic [WORD_W-1:0] dataA_in,
  input  logic [WORD_W-1:0] dataB_in,
  input  logic [WORD_W-1:0] dataC_in,
  input  logic [WORD_W-1:0] dataD_in,
  output logic [NUM_CH-1:0] grant,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [WORD_W-1:0] buf_wdata,
  output logic [NUM_CH-1:0] done,
  output logic              busy,
  output logic [15:0]       sat_count
);
  state_e state_q, state_d;
  logic [NUM_CH-1:0] grant_q, arb_gnt;
  logic [1:0] ptr_q;
  logic [ADDR_W-1:0] cnt_q, addr_q;
  logic we_q, wr, last;
  logic [WORD_W-1:0] wdata_q, word;

  rr_arbiter4 u_arb (.req_i(req), .ptr_i(ptr_q), .gnt_o(arb_gnt));

  assign wr = state_q == CAPTURE && data_valid;
  assign last = cnt_q == ADDR_W'(CAP_LEN - 1);
  assign word = ptr_q == 2'd0 ? dataA_in : ptr_q == 2'd1 ? dataB_in : ptr_q == 2'd2 ? dataC_in : dataD_in;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = req != '0 ? ARB : IDLE;
      ARB:        state_d = arb_gnt != '0 ? WAIT_VALID : IDLE;
      WAIT_VALID: state_d = data_valid ? CAPTURE : WAIT_VALID;
      CAPTURE:    state_d = wr && last ? DONE : CAPTURE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_div_a) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= 2'd3;
      cnt_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= wr;
      if (state_q == ARB) begin
        grant_q <= arb_gnt;
        cnt_q <= '0;
        addr_q <= '0;
        if (arb_gnt != '0) ptr_q <= {arb_gnt[3] | arb_gnt[2], arb_gnt[3] | arb_gnt[1]};
      end
      if (state_q == DONE) grant_q <= '0;
      if (wr) begin
        addr_q <= cnt_q;
        cnt_q <= cnt_q + ADDR_W'(1);
        wdata_q <= word;
      end
    end
  end

  assign grant = grant_q;
  assign buf_we = we_q;
  assign buf_addr = addr_q;
  assign buf_wdata = wdata_q;
  assign done = state_q == DONE ? grant_q : '0;
  assign busy = state_q != IDLE;

`ifdef ADC_CAPTURE_SAT_DETECT_EN
  logic [15:0] sat_q;
  logic [16:0] sat_sum;
  assign sat_sum = {1'b0, sat_q} + 17'(sat_in_word(word));
  always_ff @(posedge clk_div_a) begin
    if (!rst_n || state_q == ARB) sat_q <= '0;
    else if (wr) sat_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end
  assign sat_count = sat_q;
`else
  assign sat_count = '0;
`endif
endmodule

// File: tb/tb_adc_capture_sched.sv
// tb_adc_capture_sched: directed stimulus feeding a scoreboard of expected writes, grants and done pulses.
module tb_adc_capture_sched;
  localparam int CAP = 4;
  localparam int AW = 2;

  typedef struct {
    logic [AW-1:0] a;
    logic [79:0]   d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic dv = 1'b0;
  logic [79:0] din [4];
  logic [3:0] grant, done;
  logic buf_we, busy;
  logic [AW-1:0] buf_addr;
  logic [79:0] buf_wdata;
  logic [15:0] sat_count;

  wr_t exp_w[$];
  logic [3:0] exp_g[$];
  logic [3:0] exp_d[$];
  logic [3:0] prev_g = '0;
  int checks = 0;
  int fails = 0;

  adc_capture_sched #(.CAP_LEN(CAP), .ADDR_W(AW)) dut (
    .clk_div_a(clk), .rst_n(rst_n), .req(req), .data_valid(dv),
    .dataA_in(din[0]), .dataB_in(din[1]), .dataC_in(din[2]), .dataD_in(din[3]),
    .grant(grant), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .done(done), .busy(busy), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Sample values stay well below the saturation codes unless sat is requested.
  function automatic logic [79:0] word_for(input int c, input int j, input bit sat);
    logic [79:0] w;
    for (int k = 0; k < 8; k++) w[k*10 +: 10] = 10'(c * 64 + j * 8 + k);
    if (sat && j == 0) w = {40'd0, 10'h1FF, 10'h200, 10'h200, 10'h200};
    return w;
  endfunction

  task automatic drive_words(input int j, input bit sat);
    for (int c = 0; c < 4; c++) din[c] = word_for(c, j, sat);
  endtask

  task automatic wait_grant();
    int t = 0;
    while (grant === 4'b0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (grant === 4'b0) chk("grant_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("busy_after", busy, 0);
  endtask

  // One full capture: first valid cycle only moves WAIT_VALID to CAPTURE.
  task automatic run_cap(input logic [3:0] oh, input logic [7:0] pat, input logic [3:0] req_after, input bit sat);
    int c, w, j;
    wr_t e;
    c = oh[1] ? 1 : oh[2] ? 2 : oh[3] ? 3 : 0;
    w = 0;
    j = 0;
    exp_g.push_back(oh);
    exp_d.push_back(oh);
    wait_grant();
    req = req_after;
    dv = 1'b1;
    drive_words(31, 1'b0);
    while (w < CAP && j < 40) begin
      @(posedge clk); #1;
      dv = pat[j % 8];
      drive_words(j, sat);
      if (dv) begin
        e.a = AW'(w);
        e.d = word_for(c, j, sat);
        exp_w.push_back(e);
        w++;
      end
      j++;
    end
    @(posedge clk); #1;
    dv = 1'b0;
    wait_idle();
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    logic [3:0] g;
    if (buf_we === 1'b1) begin
      if (exp_w.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = exp_w.pop_front();
        chk("buf_addr", buf_addr, e.a);
        chk("buf_wdata", buf_wdata, e.d);
      end
    end
    if (done !== 4'b0) begin
      if (exp_d.size() == 0) chk("unexpected_done", done, 0);
      else begin
        g = exp_d.pop_front();
        chk("done", done, g);
      end
    end
    if (grant !== 4'b0 && prev_g === 4'b0) begin
      if (exp_g.size() == 0) chk("unexpected_grant", grant, 0);
      else begin
        g = exp_g.pop_front();
        chk("grant", grant, g);
      end
    end
    prev_g = grant;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive_words(30, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_we", buf_we, 0);
    chk("rst_addr", buf_addr, 0);
    chk("rst_wdata", buf_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat_count, 0);
    rst_n = 1'b1;
    req = 4'b0001;
    run_cap(4'b0001, 8'hFF, 4'b0000, 1'b0);
    chk("sat_plain", sat_count, 0);
    req = 4'b0010;
    run_cap(4'b0010, 8'b1101_1101, 4'b0000, 1'b0);
    req = 4'b0100;
    exp_g.push_back(4'b0100);
    wait_grant();
    req = 4'b0000;
    dv = 1'b1;
    drive_words(31, 1'b0);
    for (int j = 0; j < 2; j++) begin
      wr_t e;
      @(posedge clk); #1;
      drive_words(j, 1'b0);
      e.a = AW'(j);
      e.d = word_for(2, j, 1'b0);
      exp_w.push_back(e);
    end
    @(posedge clk); #1;
    drive_words(2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_we", buf_we, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_done", done, 0);
    end
    dv = 1'b0;
    rst_n = 1'b1;
    req = 4'b1111;
    run_cap(4'b0001, 8'hFF, 4'b1111, 1'b0);
    run_cap(4'b0010, 8'hFF, 4'b1111, 1'b0);
    run_cap(4'b0100, 8'hFF, 4'b1111, 1'b0);
    run_cap(4'b1000, 8'hFF, 4'b1111, 1'b0);
    run_cap(4'b0001, 8'hFF, 4'b0000, 1'b0);
    req = 4'b1000;
    run_cap(4'b1000, 8'hFF, 4'b0000, 1'b1);
`ifdef ADC_CAPTURE_SAT_DETECT_EN
    chk("sat_count", sat_count, 4);
`else
    chk("sat_count", sat_count, 0);
`endif
    repeat (4) @(posedge clk);
    #1;
    chk("pending_writes", exp_w.size(), 0);
    chk("pending_grants", exp_g.size(), 0);
    chk("pending_dones", exp_d.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
